round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//   Sequences a multi-round game: lobby -> countdown -> play -> round-over, repeated until a player wins.
//   Consumes per-player crash flags from the line/collision datapath and tracks which players are alive.
//   Keeps saturating per-player scores; gates the movement tick to the line engines; requests screen clears.
//   Sits between the player-select switches / new-game button and the four player line drawers.
// PARAMETERS
//   COUNT_CYCLES  100_000_000  countdown length before each round, in clk_i cycles (>=2)
//   OVER_CYCLES   200_000_000  round-over hold time before next countdown, in clk_i cycles (>=2)
//   WIN_SCORE     5            score that ends the game (1..15)
// PORTS
//   clk_i            in   1   system clock
//   rst_i            in   1   synchronous reset, active-high
//   new_game_i       in   1   single-cycle start/restart pulse (already debounced)
//   player_en_i      in   4   player enable switches, bit n = player n
//   crash_i          in   4   crash flag per player from collision logic; sampled only in PLAY
//   tick_i           in   1   movement tick from the rate divider
//   state_o          out  2   0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 ROUND_OVER
//   active_players_o out  4   players taking part in the game
//   alive_o          out  4   players still alive in the current round
//   move_en_o        out  1   registered tick_i gated by PLAY; one-cycle pulse, one-cycle latency
//   clear_screen_o   out  1   one-cycle pulse that requests a framebuffer clear
//   winner_valid_o   out  1   high in ROUND_OVER when exactly one survivor; low on a draw
//   winner_o         out  2   survivor index; valid while winner_valid_o is high
//   score_o          out  16  {s3,s2,s1,s0}, 4 bits each, saturating at 15
//   game_over_o      out  1   set when a score reaches WIN_SCORE; cleared by new_game_i
// BEHAVIOUR
// - Reset: state IDLE; every output 0, including active_players_o; counter 0.
// - popcnt(x): number of set bits. Counter: 32-bit; cleared on every state entry.
// - IDLE: active_players_o <= player_en_i each cycle.
//     new_game_i && popcnt(player_en_i)>=2 -> COUNTDOWN; scores <= 0; game_over_o <= 0; clear_screen_o pulse.
//     new_game_i with popcnt<2 is ignored; state, scores and game_over_o are unchanged.
// - COUNTDOWN: active_players_o still follows player_en_i while this is the first round of the game.
//     The counter increments each cycle. At count==COUNT_CYCLES-1:
//       popcnt(active_players_o)>=2 -> PLAY and alive_o <= active_players_o;
//       otherwise -> IDLE, and scores are kept.
//     From round 2 onward, active_players_o is frozen.
// - PLAY:
//     next_alive = alive_o & ~crash_i; crash bits for players that are not alive are ignored.
//     popcnt(next_alive)==1 -> ROUND_OVER; winner_o = index; winner_valid_o = 1; that score +1, saturating.
//     popcnt(next_alive)==0 (simultaneous final crashes) -> ROUND_OVER as a draw; winner_valid_o = 0; no score change.
//     move_en_o <= tick_i && state==PLAY, so a tick that arrives in the exit cycle still produces a pulse.
// - ROUND_OVER: alive_o, winner_* and scores hold. When count==OVER_CYCLES-1:
//     any score >= WIN_SCORE -> game_over_o <= 1; IDLE.
//     otherwise -> COUNTDOWN; clear_screen_o pulse; winner_valid_o <= 0.
// - new_game_i in COUNTDOWN, PLAY or ROUND_OVER aborts the game:
//     same checks and actions as in IDLE, then re-enters COUNTDOWN at round 1.
//     new_game_i takes priority over crash and timer events in the same cycle.
// - rst_i in any state returns to the reset values on the next edge.
// - clear_screen_o and move_en_o are never high for more than one cycle per event.
// CONFIGURATION
//   ROUND_CTRL_PAUSE_EN defined:
//     adds input pause_i (1 bit, level-sensitive);
//     while high in COUNTDOWN/PLAY/ROUND_OVER: counter frozen, crash_i ignored, move_en_o held 0;
//     new_game_i and rst_i still act.
//   Undefined: no pause_i port; behaviour as above.
// TESTING  (COUNT_CYCLES=4, OVER_CYCLES=3, WIN_SCORE=2)
// - Reset, then player_en_i=4'b0001, new_game_i -> stays IDLE, clear_screen_o stays 0.
// - player_en_i=4'b0101, new_game_i -> clear_screen_o 1 cycle, COUNTDOWN for 4 cycles, then PLAY with alive_o=0101.
// - In PLAY, crash_i=0100 -> ROUND_OVER, winner_o=0, winner_valid_o=1, score_o=16'h0001; 3 cycles later COUNTDOWN + clear pulse.
// - Round 2, crash_i=0101 in the same cycle -> draw, winner_valid_o=0, score_o unchanged.
// - P0 wins a second round -> after OVER_CYCLES, game_over_o=1, state IDLE; then new_game_i -> score_o=0, game_over_o=0.
// - tick_i pulses in COUNTDOWN -> move_en_o=0; in PLAY -> move_en_o 1 cycle after each tick; new_game_i mid-PLAY -> COUNTDOWN, scores 0.

Source files
------------

// File: rtl/round_controller.sv
// round_controller: multi-round game sequencer (lobby -> countdown -> play -> round-over).
// Tracks active and alive players, keeps saturating 4-bit scores per player,
// gates the movement tick to the line engines and requests screen clears.
// Optional build macro ROUND_CTRL_PAUSE_EN adds a level-sensitive pause_i input.
module round_controller #(
  parameter int unsigned COUNT_CYCLES = 100_000_000,
  parameter int unsigned OVER_CYCLES  = 200_000_000,
  parameter int unsigned WIN_SCORE    = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef ROUND_CTRL_PAUSE_EN
  input  logic        pause_i,
`endif
  input  logic        new_game_i,
  input  logic [3:0]  player_en_i,
  input  logic [3:0]  crash_i,
  input  logic        tick_i,
  output logic [1:0]  state_o,
  output logic [3:0]  active_players_o,
  output logic [3:0]  alive_o,
  output logic        move_en_o,
  output logic        clear_screen_o,
  output logic        winner_valid_o,
  output logic [1:0]  winner_o,
  output logic [15:0] score_o,
  output logic        game_over_o
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_COUNTDOWN  = 2'd1,
    S_PLAY       = 2'd2,
    S_ROUND_OVER = 2'd3
  } state_t;

  localparam logic [31:0] COUNT_LAST = COUNT_CYCLES - 1;
  localparam logic [31:0] OVER_LAST  = OVER_CYCLES - 1;
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);

  state_t          state;
  logic [31:0]     count;
  logic            first_round;
  logic [3:0][3:0] scores;
  logic [3:0]      next_alive;
  logic            start_ok;
  logic            any_win;
  logic            paused;

  function automatic logic [2:0] popcnt4(input logic [3:0] x);
    popcnt4 = {2'b00, x[0]} + {2'b00, x[1]} + {2'b00, x[2]} + {2'b00, x[3]};
  endfunction

  function automatic logic [1:0] one_hot_index(input logic [3:0] x);
    one_hot_index = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (x[i]) one_hot_index = 2'(i);
    end
  endfunction

`ifdef ROUND_CTRL_PAUSE_EN
  assign paused = pause_i;
`else
  assign paused = 1'b0;
`endif

  assign state_o    = state;
  assign score_o    = scores;
  assign next_alive = alive_o & ~crash_i;
  assign start_ok   = new_game_i && (popcnt4(player_en_i) >= 3'd2);

  // Flag when any player has reached the winning score.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    any_win = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (scores[i] >= WIN) any_win = 1'b1;
    end
  end

  // Game sequencer with registered outputs; a valid new_game_i overrides timer and crash events.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the score registers are ordinary flops, not a memory, so they reset with everything else.
      state            <= S_IDLE;
      count            <= '0;
      first_round      <= 1'b0;
      scores           <= '0;
      active_players_o <= '0;
      alive_o          <= '0;
      move_en_o        <= 1'b0;
      clear_screen_o   <= 1'b0;
      winner_valid_o   <= 1'b0;
      winner_o         <= '0;
      game_over_o      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads last cycle's state.
      clear_screen_o <= 1'b0;
      move_en_o      <= tick_i && (state == S_PLAY) && !paused;

      if (start_ok) begin
        state            <= S_COUNTDOWN;
        count            <= '0;
        first_round      <= 1'b1;
        scores           <= '0;
        game_over_o      <= 1'b0;
        clear_screen_o   <= 1'b1;
        active_players_o <= player_en_i;
        alive_o          <= '0;
        winner_valid_o   <= 1'b0;
        winner_o         <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            active_players_o <= player_en_i;
          end

          S_COUNTDOWN: begin
            if (first_round) active_players_o <= player_en_i;
            if (!paused) begin
              if (count == COUNT_LAST) begin
                count <= '0;
                if (popcnt4(active_players_o) >= 3'd2) begin
                  state   <= S_PLAY;
                  alive_o <= active_players_o;
                end else begin
                  state <= S_IDLE;
                end
              end else begin
                count <= count + 32'd1;
              end
            end
          end

          S_PLAY: begin
            if (!paused) begin
              alive_o <= next_alive;
              if (popcnt4(next_alive) == 3'd1) begin
                state          <= S_ROUND_OVER;
                count          <= '0;
                winner_valid_o <= 1'b1;
                winner_o       <= one_hot_index(next_alive);
                if (scores[one_hot_index(next_alive)] != 4'hF)
                  scores[one_hot_index(next_alive)] <= scores[one_hot_index(next_alive)] + 4'd1;
              end else if (popcnt4(next_alive) == 3'd0) begin
                state          <= S_ROUND_OVER;
                count          <= '0;
                winner_valid_o <= 1'b0;
              end
            end
          end

          S_ROUND_OVER: begin
            if (!paused) begin
              if (count == OVER_LAST) begin
                count          <= '0;
                winner_valid_o <= 1'b0;
                if (any_win) begin
                  state       <= S_IDLE;
                  game_over_o <= 1'b1;
                end else begin
                  state          <= S_COUNTDOWN;
                  first_round    <= 1'b0;
                  clear_screen_o <= 1'b1;
                end
              end else begin
                count <= count + 32'd1;
              end
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb_round_controller: directed scoreboard bench for round_controller
// with COUNT_CYCLES=4, OVER_CYCLES=3, WIN_SCORE=2.
module tb_round_controller;

  localparam int unsigned COUNT_CYCLES = 4;
  localparam int unsigned OVER_CYCLES  = 3;
  localparam int unsigned WIN_SCORE    = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CD   = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_RO   = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        new_game_i;
  logic [3:0]  player_en_i;
  logic [3:0]  crash_i;
  logic        tick_i;
  logic [1:0]  state_o;
  logic [3:0]  active_players_o;
  logic [3:0]  alive_o;
  logic        move_en_o;
  logic        clear_screen_o;
  logic        winner_valid_o;
  logic [1:0]  winner_o;
  logic [15:0] score_o;
  logic        game_over_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  round_controller #(
    .COUNT_CYCLES(COUNT_CYCLES),
    .OVER_CYCLES (OVER_CYCLES),
    .WIN_SCORE   (WIN_SCORE)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
`ifdef ROUND_CTRL_PAUSE_EN
    .pause_i         (1'b0),
`endif
    .new_game_i      (new_game_i),
    .player_en_i     (player_en_i),
    .crash_i         (crash_i),
    .tick_i          (tick_i),
    .state_o         (state_o),
    .active_players_o(active_players_o),
    .alive_o         (alive_o),
    .move_en_o       (move_en_o),
    .clear_screen_o  (clear_screen_o),
    .winner_valid_o  (winner_valid_o),
    .winner_o        (winner_o),
    .score_o         (score_o),
    .game_over_o     (game_over_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic push_core(input string tag, input logic [1:0] st, input logic clr, input logic mv);
    push({tag, ".state"}, 32'(st));
    push({tag, ".clear"}, 32'(clr));
    push({tag, ".move"}, 32'(mv));
  endtask

  task automatic check_core();
    check(32'(state_o));
    check(32'(clear_screen_o));
    check(32'(move_en_o));
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // n countdown cycles with no clear pulse and no movement
  task automatic countdown_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push_core(tag, S_CD, 1'b0, 1'b0);
      cyc();
      check_core();
    end
  endtask

  task automatic over_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      push_core(tag, S_RO, 1'b0, 1'b0);
      cyc();
      check_core();
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    new_game_i  = 1'b0;
    player_en_i = 4'b0000;
    crash_i     = 4'b0000;
    tick_i      = 1'b0;

    // Reset values
    push_core("reset", S_IDLE, 1'b0, 1'b0);
    push("reset.active", 32'h0);
    push("reset.alive", 32'h0);
    push("reset.score", 32'h0);
    push("reset.gameover", 32'h0);
    push("reset.wvalid", 32'h0);
    cyc();
    cyc();
    check_core();
    check(32'(active_players_o));
    check(32'(alive_o));
    check(32'(score_o));
    check(32'(game_over_o));
    check(32'(winner_valid_o));
    rst_i = 1'b0;

    // One player only: new game ignored
    player_en_i = 4'b0001;
    new_game_i  = 1'b1;
    push_core("solo", S_IDLE, 1'b0, 1'b0);
    push("solo.active", 32'h1);
    cyc();
    new_game_i = 1'b0;
    check_core();
    check(32'(active_players_o));

    // Two players: start game
    player_en_i = 4'b0101;
    new_game_i  = 1'b1;
    push_core("start", S_CD, 1'b1, 1'b0);
    push("start.score", 32'h0);
    cyc();
    new_game_i = 1'b0;
    check_core();
    check(32'(score_o));

    // Countdown with a tick that must not move anything
    for (int i = 1; i < 4; i++) begin
      tick_i = (i == 2);
      push_core("cd1", S_CD, 1'b0, 1'b0);
      cyc();
      check_core();
    end
    tick_i = 1'b0;
    push_core("play1", S_PLAY, 1'b0, 1'b0);
    push("play1.alive", 32'h5);
    cyc();
    check_core();
    check(32'(alive_o));

    // Ticks in PLAY produce one-cycle pulses
    tick_i = 1'b1;
    push_core("tick_on", S_PLAY, 1'b0, 1'b1);
    cyc();
    check_core();
    tick_i = 1'b0;
    push_core("tick_off", S_PLAY, 1'b0, 1'b0);
    cyc();
    check_core();

    // P2 crashes: P0 wins round 1
    crash_i = 4'b0100;
    push_core("win1", S_RO, 1'b0, 1'b0);
    push("win1.winner", 32'h0);
    push("win1.wvalid", 32'h1);
    push("win1.score", 32'h0001);
    push("win1.alive", 32'h1);
    cyc();
    crash_i = 4'b0000;
    check_core();
    check(32'(winner_o));
    check(32'(winner_valid_o));
    check(32'(score_o));
    check(32'(alive_o));
    over_cycles("ro1", 2);
    push_core("next2", S_CD, 1'b1, 1'b0);
    push("next2.wvalid", 32'h0);
    cyc();
    check_core();
    check(32'(winner_valid_o));

    // Round 2: active players frozen even if switches change
    player_en_i = 4'b1111;
    push_core("frz", S_CD, 1'b0, 1'b0);
    push("frz.active", 32'h5);
    cyc();
    check_core();
    check(32'(active_players_o));
    player_en_i = 4'b0101;
    countdown_cycles("cd2", 2);
    push_core("play2", S_PLAY, 1'b0, 1'b0);
    push("play2.alive", 32'h5);
    cyc();
    check_core();
    check(32'(alive_o));

    // Simultaneous final crashes: draw
    crash_i = 4'b0101;
    push_core("draw", S_RO, 1'b0, 1'b0);
    push("draw.wvalid", 32'h0);
    push("draw.score", 32'h0001);
    push("draw.alive", 32'h0);
    cyc();
    crash_i = 4'b0000;
    check_core();
    check(32'(winner_valid_o));
    check(32'(score_o));
    check(32'(alive_o));
    over_cycles("ro2", 2);
    push_core("next3", S_CD, 1'b1, 1'b0);
    cyc();
    check_core();
    countdown_cycles("cd3", 3);
    push_core("play3", S_PLAY, 1'b0, 1'b0);
    cyc();
    check_core();

    // P0 wins again, with a tick in the exit cycle
    crash_i = 4'b0100;
    tick_i  = 1'b1;
    push_core("win3", S_RO, 1'b0, 1'b1);
    push("win3.winner", 32'h0);
    push("win3.wvalid", 32'h1);
    push("win3.score", 32'h0002);
    cyc();
    crash_i = 4'b0000;
    tick_i  = 1'b0;
    check_core();
    check(32'(winner_o));
    check(32'(winner_valid_o));
    check(32'(score_o));
    over_cycles("ro3", 2);
    push_core("gover", S_IDLE, 1'b0, 1'b0);
    push("gover.flag", 32'h1);
    push("gover.score", 32'h0002);
    cyc();
    check_core();
    check(32'(game_over_o));
    check(32'(score_o));

    // Restart clears scores and game over
    new_game_i = 1'b1;
    push_core("restart", S_CD, 1'b1, 1'b0);
    push("restart.score", 32'h0);
    push("restart.gover", 32'h0);
    cyc();
    new_game_i = 1'b0;
    check_core();
    check(32'(score_o));
    check(32'(game_over_o));
    countdown_cycles("cd4", 3);
    push_core("play4", S_PLAY, 1'b0, 1'b0);
    cyc();
    check_core();

    // P0 crashes: P2 wins
    crash_i = 4'b0001;
    push_core("win4", S_RO, 1'b0, 1'b0);
    push("win4.winner", 32'h2);
    push("win4.score", 32'h0100);
    cyc();
    crash_i = 4'b0000;
    check_core();
    check(32'(winner_o));
    check(32'(score_o));
    over_cycles("ro4", 2);
    push_core("next5", S_CD, 1'b1, 1'b0);
    cyc();
    check_core();
    countdown_cycles("cd5", 3);
    push_core("play5", S_PLAY, 1'b0, 1'b0);
    cyc();
    check_core();

    // new_game mid-PLAY beats a simultaneous crash
    new_game_i = 1'b1;
    crash_i    = 4'b0001;
    push_core("abort", S_CD, 1'b1, 1'b0);
    push("abort.score", 32'h0);
    push("abort.wvalid", 32'h0);
    cyc();
    new_game_i = 1'b0;
    crash_i    = 4'b0000;
    check_core();
    check(32'(score_o));
    check(32'(winner_valid_o));

    // Every expectation consumed
    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
